// File: rtl/perf_stat_pkg.sv
// Shared constants for the performance statistics selector: channel indices
// and display-select codes.
package perf_stat_pkg;

   localparam int unsigned SEL_W = 4;

   typedef logic [SEL_W-1:0] sel_t;

   localparam int unsigned CH_CYCLE        = 0;
   localparam int unsigned CH_JUMP         = 1;
   localparam int unsigned CH_BRANCH       = 2;
   localparam int unsigned CH_BRANCH_TAKEN = 3;
   localparam int unsigned CH_SYSCALL      = 4;

   localparam sel_t SEL_RAW = sel_t'(0);

   // Select code that shows counter channel k on the display.
   function automatic sel_t SEL_CH(input int unsigned k);
      return sel_t'(k + 1);
   endfunction

endpackage

// File: rtl/perf_stat_sel_counter.sv
// Single event counter with a sticky overflow flag; saturates or wraps
// depending on SAT_MODE. Clear takes priority over increment.
module stat_counter #(
   parameter int unsigned CNT_W    = 16,
   parameter bit          SAT_MODE = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] value,
   output logic             flag
);

   logic [CNT_W-1:0] value_q, value_d;
   logic             flag_q, flag_d;

   always_comb begin
      value_d = value_q;
      flag_d  = flag_q;
      if (clr) begin
         value_d = '0;
         flag_d  = 1'b0;
      end else if (inc) begin
         if (&value_q) begin
            // Overflow: hold at max when saturating, otherwise roll to zero.
            flag_d = 1'b1;
            if (!SAT_MODE) value_d = '0;
         end else begin
            value_d = value_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_q <= '0;
         flag_q  <= 1'b0;
      end else begin
         value_q <= value_d;
         flag_q  <= flag_d;
      end
   end

   assign value = value_q;
   assign flag  = flag_q;

endmodule

// File: rtl/perf_stat_sel.sv
// Bank of event counters with a registered, freezable display mux that shows
// either raw pass-through data or one zero-extended counter.
module perf_stat_sel
   import perf_stat_pkg::*;
#(
   parameter int unsigned NUM_CH   = 5,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned DATA_W   = 32,
   parameter bit          SAT_MODE = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              halt,
   input  logic [NUM_CH-1:0] ev,
   input  logic              clr,
   input  logic [SEL_W-1:0]  sel,
   input  logic              freeze,
   input  logic [DATA_W-1:0] raw_in,
   output logic [DATA_W-1:0] disp_out,
   output logic [NUM_CH-1:0] sat_flag,
   output logic              sel_err
);

   logic [CNT_W-1:0]  cnt_val [NUM_CH];
   logic [DATA_W-1:0] disp_out_q, disp_out_d;
   logic              sel_err_q, sel_err_d;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      stat_counter #(
         .CNT_W    (CNT_W),
         .SAT_MODE (SAT_MODE)
      ) u_cnt (
         .clk   (clk),
         .reset (reset),
         .inc   (ev[g] & ~halt),
         .clr   (clr),
         .value (cnt_val[g]),
         .flag  (sat_flag[g])
      );
   end

   // Display mux samples pre-update counter values, so it lags a count by one edge.
   always_comb begin
      disp_out_d = disp_out_q;
      sel_err_d  = sel_err_q;
      if (!freeze) begin
         sel_err_d  = (sel > sel_t'(NUM_CH));
         disp_out_d = '0;
         if (sel == SEL_RAW) disp_out_d = raw_in;
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (sel == SEL_CH(k)) disp_out_d = DATA_W'(cnt_val[k]);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp_out_q <= '0;
         sel_err_q  <= 1'b0;
      end else begin
         disp_out_q <= disp_out_d;
         sel_err_q  <= sel_err_d;
      end
   end

   assign disp_out = disp_out_q;
   assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_perf_stat_sel.sv
// Bench for perf_stat_sel: three configurations share one stimulus stream and
// are compared every cycle against an integer reference model.
module tb_perf_stat_sel;

   localparam int NCH = 5;

   logic        clk = 1'b0;
   logic        reset, halt, clr, freeze;
   logic [4:0]  ev;
   logic [3:0]  sel;
   logic [31:0] raw_in;

   logic [31:0] disp0, disp1, disp2;
   logic [4:0]  sat0, sat1, sat2;
   logic        err0, err1, err2;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   // Reference state per configuration: 0 = 16-bit saturating, 1 = 4-bit saturating, 2 = 4-bit wrapping.
   int          cnt      [3][NCH];
   bit          flg      [3][NCH];
   logic [31:0] exp_disp [3];
   bit          exp_err  [3];

   always #5 clk = ~clk;

   perf_stat_sel #(.NUM_CH(5), .CNT_W(16), .DATA_W(32), .SAT_MODE(1'b1)) u_dut0 (
      .clk(clk), .reset(reset), .halt(halt), .ev(ev), .clr(clr), .sel(sel),
      .freeze(freeze), .raw_in(raw_in), .disp_out(disp0), .sat_flag(sat0), .sel_err(err0));

   perf_stat_sel #(.NUM_CH(5), .CNT_W(4), .DATA_W(32), .SAT_MODE(1'b1)) u_dut1 (
      .clk(clk), .reset(reset), .halt(halt), .ev(ev), .clr(clr), .sel(sel),
      .freeze(freeze), .raw_in(raw_in), .disp_out(disp1), .sat_flag(sat1), .sel_err(err1));

   perf_stat_sel #(.NUM_CH(5), .CNT_W(4), .DATA_W(32), .SAT_MODE(1'b0)) u_dut2 (
      .clk(clk), .reset(reset), .halt(halt), .ev(ev), .clr(clr), .sel(sel),
      .freeze(freeze), .raw_in(raw_in), .disp_out(disp2), .sat_flag(sat2), .sel_err(err2));

   function automatic int maxv(input int c);
      return (c == 0) ? 65535 : 15;
   endfunction

   function automatic logic [31:0] flagvec(input int c);
      logic [31:0] v = '0;
      for (int i = 0; i < NCH; i++) v[i] = flg[c][i];
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < NCH; i++) begin
            cnt[c][i] = 0;
            flg[c][i] = 1'b0;
         end
         exp_disp[c] = '0;
         exp_err[c]  = 1'b0;
      end
   endtask

   // One clock edge of the reference behaviour, using inputs as seen at the edge.
   task automatic model_step();
      if (reset) return;
      for (int c = 0; c < 3; c++) begin
         if (!freeze) begin
            exp_err[c] = (int'(sel) > NCH);
            if (sel == 0)              exp_disp[c] = raw_in;
            else if (int'(sel) <= NCH) exp_disp[c] = 32'(cnt[c][int'(sel) - 1]);
            else                       exp_disp[c] = '0;
         end
         if (clr) begin
            for (int i = 0; i < NCH; i++) begin
               cnt[c][i] = 0;
               flg[c][i] = 1'b0;
            end
         end else if (!halt) begin
            for (int i = 0; i < NCH; i++) begin
               if (ev[i]) begin
                  if (cnt[c][i] == maxv(c)) begin
                     flg[c][i] = 1'b1;
                     cnt[c][i] = (c == 2) ? 0 : cnt[c][i];
                  end else begin
                     cnt[c][i] = cnt[c][i] + 1;
                  end
               end
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // Asserts reset between edges and confirms outputs clear without a clock.
   task automatic do_reset();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk("async_rst_disp0", disp0, 32'h0);
      chk("async_rst_disp1", disp1, 32'h0);
      chk("async_rst_disp2", disp2, 32'h0);
      chk("async_rst_sat0", {27'b0, sat0}, 32'h0);
      chk("async_rst_sat1", {27'b0, sat1}, 32'h0);
      chk("async_rst_sat2", {27'b0, sat2}, 32'h0);
      chk("async_rst_err0", {31'b0, err0}, 32'h0);
      chk("async_rst_err1", {31'b0, err1}, 32'h0);
      chk("async_rst_err2", {31'b0, err2}, 32'h0);
      cycle();
      cycle();
      reset = 1'b0;
   endtask

   // Every-cycle comparison of all three configurations against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("disp_c0", disp0, exp_disp[0]);
         chk("disp_c1", disp1, exp_disp[1]);
         chk("disp_c2", disp2, exp_disp[2]);
         chk("sat_c0", {27'b0, sat0}, flagvec(0));
         chk("sat_c1", {27'b0, sat1}, flagvec(1));
         chk("sat_c2", {27'b0, sat2}, flagvec(2));
         chk("err_c0", {31'b0, err0}, {31'b0, exp_err[0]});
         chk("err_c1", {31'b0, err1}, {31'b0, exp_err[1]});
         chk("err_c2", {31'b0, err2}, {31'b0, exp_err[2]});
      end
   end

   initial begin
      reset = 1'b0; halt = 1'b0; clr = 1'b0; freeze = 1'b0;
      ev = '0; sel = '0; raw_in = '0;
      model_reset();
      #3;
      do_reset();
      chk_en = 1'b1;

      // Ten cycle ticks then select channel 0.
      ev = 5'b00001;
      repeat (10) cycle();
      ev = '0; sel = 4'd1;
      cycle();
      chk("tick10_disp", disp0, 32'h0000000A);
      chk("tick10_err", {31'b0, err0}, 32'h0);

      // Twenty pulses on channel 1: saturate vs wrap in the 4-bit builds.
      do_reset();
      ev = 5'b00010;
      repeat (20) cycle();
      ev = '0; sel = 4'd2;
      cycle();
      chk("sat4_disp", disp1, 32'h0000000F);
      chk("sat4_flag", {31'b0, sat1[1]}, 32'h1);
      chk("wrap4_disp", disp2, 32'h00000004);
      chk("wrap4_flag", {31'b0, sat2[1]}, 32'h1);
      chk("wide_disp", disp0, 32'h00000014);
      chk("wide_flag", {27'b0, sat0}, 32'h0);

      // Clear beats a simultaneous event; halt blocks events.
      do_reset();
      sel = 4'd3; ev = 5'b00100;
      repeat (7) cycle();
      ev = '0;
      cycle();
      chk("ch2_seven", disp0, 32'h7);
      ev = 5'b00100; clr = 1'b1;
      cycle();
      ev = '0; clr = 1'b0;
      cycle();
      chk("clr_priority", disp0, 32'h0);
      ev = 5'b00100;
      repeat (3) cycle();
      halt = 1'b1;
      repeat (4) cycle();
      halt = 1'b0; ev = '0;
      cycle();
      chk("halt_hold", disp0, 32'h3);

      // Freeze holds raw pass-through until released.
      sel = 4'd0; raw_in = 32'h00400020;
      cycle();
      chk("raw_pass", disp0, 32'h00400020);
      freeze = 1'b1; raw_in = 32'h00400024;
      repeat (3) cycle();
      chk("freeze_hold", disp0, 32'h00400020);
      freeze = 1'b0;
      cycle();
      chk("freeze_release", disp0, 32'h00400024);

      // Out-of-range select.
      sel = 4'd9;
      cycle();
      chk("sel9_disp", disp0, 32'h0);
      chk("sel9_err", {31'b0, err0}, 32'h1);

      // Reset mid-count with nonzero counters and flags.
      sel = 4'd1; ev = 5'b11111;
      repeat (20) cycle();
      do_reset();
      ev = '0;

      // Randomized traffic.
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 4) == 0) sel = 4'($urandom_range(0, 15));
         ev     = 5'($urandom);
         if ($urandom_range(0, 3) != 0) ev[0] = 1'b1;
         clr    = ($urandom_range(0, 39) == 0);
         halt   = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 9) == 0) freeze = ~freeze;
         raw_in = $urandom;
         if ($urandom_range(0, 499) == 0) do_reset();
         else cycle();
      end

      ev = '0; clr = 1'b0; halt = 1'b0; freeze = 1'b0;
      cycle();
      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/perf_stat_sel.md
PERF_STAT_SEL -- requirements
Module: perf_stat_sel

Interface
REQ-001 Parameter NUM_CH, default 5, is the number of event counter channels (1..15).
REQ-002 Parameter CNT_W, default 16, is the width of each counter (1..DATA_W).
REQ-003 Parameter DATA_W, default 32, is the width of the display output.
REQ-004 Parameter SAT_MODE, default 1: 1 = counters saturate; 0 = counters wrap.
REQ-005 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1, asynchronous active-high reset.
REQ-007 Port halt, input, 1, high suspends all counting.
REQ-008 Port ev, input, NUM_CH, per-channel single-cycle event strobes; ev[0] is the cycle tick.
REQ-009 Port clr, input, 1, synchronous clear of all counters and flags.
REQ-010 Port sel, input, 4, display select: 0 = raw_in; k in 1..NUM_CH = counter k-1.
REQ-011 Port freeze, input, 1, high holds disp_out at its current value.
REQ-012 Port raw_in, input, DATA_W, pass-through data such as PC or syscall output.
REQ-013 Port disp_out, output, DATA_W, registered display value.
REQ-014 Port sat_flag, output, NUM_CH, sticky per-channel overflow indicator.
REQ-015 Port sel_err, output, 1, registered indicator that sel is out of range.

Function
REQ-016 Counter i SHALL increment by 1 on a clock edge where ev[i]=1, halt=0, clr=0.
REQ-017 With SAT_MODE=1, a counter at 2^CNT_W-1 SHALL hold its value on a further event and set sat_flag[i].
REQ-018 With SAT_MODE=0, a counter SHALL wrap from 2^CNT_W-1 to 0 and set sat_flag[i] on that wrap.
REQ-019 sat_flag[i] SHALL stay set until the next clr or reset.
REQ-020 clr SHALL zero all counters and sat_flag on the next edge and SHALL take priority over simultaneous events.
REQ-021 halt=1 SHALL block increments on every channel, ev[0] included; counter values are held.
REQ-022 disp_out SHALL be loaded every edge with freeze=0, one cycle after sel, raw_in or a counter value changes.
REQ-023 For a counter source, disp_out SHALL be zero-extended: bits DATA_W-1..CNT_W = 0.
REQ-024 When sel > NUM_CH, disp_out SHALL load 0 and sel_err SHALL be 1, both one cycle later.
REQ-025 With freeze=1, disp_out and sel_err SHALL hold; counters SHALL continue counting.
REQ-026 A clr applied during freeze SHALL clear the counters but SHALL NOT change disp_out until freeze drops.
REQ-027 The block SHALL have no combinational path from any input to any output.

Reset
REQ-028 reset=1 SHALL asynchronously force all counters, sat_flag, disp_out and sel_err to 0.
REQ-029 Reset SHALL override clr, halt, freeze and ev.
REQ-030 After reset deasserts, the first edge SHALL behave per REQ-016..REQ-026.

Structure
REQ-031 Package perf_stat_pkg SHALL hold:
- channel index constants CH_CYCLE=0, CH_JUMP=1, CH_BRANCH=2, CH_BRANCH_TAKEN=3, CH_SYSCALL=4;
- sel code constants SEL_RAW=0 and SEL_CH(k)=k+1.
REQ-032 One sub-module, stat_counter, SHALL implement a single CNT_W counter:
- inputs inc, clr and the SAT_MODE parameter;
- outputs value and the sticky flag;
- instantiated NUM_CH times by a generate loop.

Verification
REQ-033 Scenario, defaults: reset, then ev[0]=1 for 10 cycles, then sel=1 -> disp_out=0x0000000A on the next edge.
REQ-034 Scenario, CNT_W=4, SAT_MODE=1: 20 pulses on ev[1], sel=2 -> disp_out=0x0000000F, sat_flag[1]=1.
REQ-035 Scenario, CNT_W=4, SAT_MODE=0: same 20 pulses -> disp_out=0x00000004, sat_flag[1]=1.
REQ-036 Scenario: ev[2] and clr both high on the same edge with counter 2 at 7 -> counter 2 reads 0 next cycle; halt=1 with ev[2] pulses -> count unchanged.
REQ-037 Scenario: sel=0, raw_in=0x00400020, freeze=1, raw_in changed to 0x00400024 -> disp_out stays 0x00400020; freeze=0 -> disp_out=0x00400024 one cycle later.
REQ-038 Scenario: sel=9 with NUM_CH=5 -> disp_out=0 and sel_err=1 next edge; reset asserted mid-count -> all outputs 0 immediately, without waiting for a clock.
